// File: rtl/sync_filter_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sync_filter_bus_pkg
// Description : Shared constant functions for the synchronising debounce bus.
// Revision    : 1.0 - initial release
// ============================================================================
package sync_filter_bus_pkg;

   // Ceiling log2; clog2(1) is 0.
   function automatic int clog2(input int value);
      int result;
      int v;
      result = 0;
      v = value - 1;
      while (v > 0) begin
         result = result + 1;
         v = v >> 1;
      end
      return result;
   endfunction

   function automatic int cnt_width(input int stable_cycles);
      return (clog2(stable_cycles) < 1) ? 1 : clog2(stable_cycles);
   endfunction

endpackage
`default_nettype wire

// File: rtl/mdetect_3.sv
`default_nettype none
// ============================================================================
// Module      : mdetect_3
// Description : Combinational 2-of-3 majority detector.
// Revision    : 1.0 - initial release
// ============================================================================
module mdetect_3 (
   input  logic i_a,
   input  logic i_b,
   input  logic i_c,
   output logic o_y
);

   assign o_y = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);

endmodule
`default_nettype wire

// File: rtl/sync_filter_bit.sv
`default_nettype none
// ============================================================================
// Module      : sync_filter_bit
// Description : One line: synchroniser, 3-sample majority, stability counter,
//               debounced output with registered edge strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_filter_bit
   import sync_filter_bus_pkg::*;
#(
   parameter int   SYNC_STAGES   = 2,
   parameter int   STABLE_CYCLES = 4,
   parameter logic RESET_VALUE   = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic i_d,
   output logic o_q,
   output logic o_rise,
   output logic o_fall,
   output logic o_strobe_nxt
);

   localparam int                c_CNT_W   = cnt_width(STABLE_CYCLES);
   localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(STABLE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_h1;
   logic                   r_h2;
   logic                   r_q;
   logic                   r_rise;
   logic                   r_fall;
   logic [c_CNT_W-1:0]     r_cnt;

   logic                   w_s;
   logic                   w_m;
   logic                   w_q_nxt;
   logic                   w_rise_nxt;
   logic                   w_fall_nxt;
   logic [c_CNT_W-1:0]     w_cnt_nxt;

   assign w_s = r_sync[SYNC_STAGES-1];

   mdetect_3 u_maj (
      .i_a (w_s),
      .i_b (r_h1),
      .i_c (r_h2),
      .o_y (w_m)
   );

   // Counter tracks consecutive cycles the filtered sample disagrees with the output.
   always_comb begin
      w_cnt_nxt  = r_cnt;
      w_q_nxt    = r_q;
      w_rise_nxt = 1'b0;
      w_fall_nxt = 1'b0;
      if (w_m == r_q) begin
         w_cnt_nxt = '0;
      end else if (r_cnt == c_CNT_MAX) begin
         w_cnt_nxt  = '0;
         w_q_nxt    = w_m;
         w_rise_nxt = w_m;
         w_fall_nxt = ~w_m;
      end else begin
         w_cnt_nxt = r_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sync <= {SYNC_STAGES{RESET_VALUE}};
         r_h1   <= RESET_VALUE;
         r_h2   <= RESET_VALUE;
         r_q    <= RESET_VALUE;
         r_cnt  <= '0;
         r_rise <= 1'b0;
         r_fall <= 1'b0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
         r_h1   <= w_s;
         r_h2   <= r_h1;
         r_q    <= w_q_nxt;
         r_cnt  <= w_cnt_nxt;
         r_rise <= w_rise_nxt;
         r_fall <= w_fall_nxt;
      end
   end

   assign o_q          = r_q;
   assign o_rise       = r_rise;
   assign o_fall       = r_fall;
   assign o_strobe_nxt = w_rise_nxt | w_fall_nxt;

endmodule
`default_nettype wire

// File: rtl/sync_filter_bus.sv
`default_nettype none
// ============================================================================
// Module      : sync_filter_bus
// Description : WIDTH independent synchronised, majority-filtered, debounced
//               lines with per-bit rise/fall strobes and a combined change flag.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_filter_bus #(
   parameter int               WIDTH         = 8,
   parameter int               SYNC_STAGES   = 2,
   parameter int               STABLE_CYCLES = 4,
   parameter logic [WIDTH-1:0] RESET_VALUE   = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d_in,
   output logic [WIDTH-1:0] d_out,
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall,
   output logic             changed
);

   logic [WIDTH-1:0] w_strobe_nxt;
   logic             r_changed;

   generate
      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
         sync_filter_bit #(
            .SYNC_STAGES   (SYNC_STAGES),
            .STABLE_CYCLES (STABLE_CYCLES),
            .RESET_VALUE   (RESET_VALUE[i])
         ) u_bit (
            .clk          (clk),
            .reset        (reset),
            .i_d          (d_in[i]),
            .o_q          (d_out[i]),
            .o_rise       (rise[i]),
            .o_fall       (fall[i]),
            .o_strobe_nxt (w_strobe_nxt[i])
         );
      end
   endgenerate

   // Registered from the per-bit next-strobe terms so it aligns with rise/fall.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_changed <= 1'b0;
      end else begin
         r_changed <= |w_strobe_nxt;
      end
   end

   assign changed = r_changed;

endmodule
`default_nettype wire

// File: tb/tb_sync_filter_bus.sv
`default_nettype none
// ============================================================================
// Module      : tb_sync_filter_bus
// Description : Self-checking bench: three configurations against a windowed
//               behavioural model, plus directed literal checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_filter_bus;

   logic       clk;
   logic       reset;
   logic [7:0] din  [3];
   logic [7:0] dout [3];
   logic [7:0] rise [3];
   logic [7:0] fall [3];
   logic       chg  [3];

   int n_tests = 0;
   int n_fail  = 0;

   // DUT0: defaults; DUT1: RESET_VALUE=0xA5; DUT2: SYNC_STAGES=3, STABLE_CYCLES=1
   sync_filter_bus u_dut0 (
      .clk(clk), .reset(reset), .d_in(din[0]), .d_out(dout[0]),
      .rise(rise[0]), .fall(fall[0]), .changed(chg[0]));

   sync_filter_bus #(.RESET_VALUE(8'hA5)) u_dut1 (
      .clk(clk), .reset(reset), .d_in(din[1]), .d_out(dout[1]),
      .rise(rise[1]), .fall(fall[1]), .changed(chg[1]));

   sync_filter_bus #(.SYNC_STAGES(3), .STABLE_CYCLES(1)) u_dut2 (
      .clk(clk), .reset(reset), .d_in(din[2]), .d_out(dout[2]),
      .rise(rise[2]), .fall(fall[2]), .changed(chg[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   // sq: last SYNC+2 input samples (oldest first); m = majority of the three oldest.
   // A bit flips when the last STABLE filtered samples all disagree with it.
   logic [7:0] sq [3][6];
   logic [7:0] mh [3][4];
   logic [7:0] eo [3];
   logic [7:0] er [3];
   logic [7:0] ef [3];
   logic       ec [3];

   function automatic int sync_of(input int k);
      return (k == 2) ? 3 : 2;
   endfunction
   function automatic int stab_of(input int k);
      return (k == 2) ? 1 : 4;
   endfunction
   function automatic logic [7:0] rv_of(input int k);
      return (k == 1) ? 8'hA5 : 8'h00;
   endfunction

   task automatic model_reset(input int k);
      for (int j = 0; j < 6; j++) sq[k][j] = rv_of(k);
      for (int j = 0; j < 4; j++) mh[k][j] = rv_of(k);
      eo[k] = rv_of(k);
      er[k] = 8'h00;
      ef[k] = 8'h00;
      ec[k] = 1'b0;
   endtask

   task automatic model_step(input int k, input logic [7:0] d);
      int         len;
      int         stab;
      logic [7:0] m;
      logic [7:0] flip;
      logic [7:0] nw;
      len  = sync_of(k) + 2;
      stab = stab_of(k);
      m = (sq[k][2] & sq[k][1]) | (sq[k][2] & sq[k][0]) | (sq[k][1] & sq[k][0]);
      for (int j = 0; j < stab - 1; j++) mh[k][j] = mh[k][j+1];
      mh[k][stab-1] = m;
      flip = 8'hFF;
      for (int j = 0; j < stab; j++) flip = flip & (mh[k][j] ^ eo[k]);
      nw    = eo[k] ^ flip;
      er[k] = nw & ~eo[k];
      ef[k] = ~nw & eo[k];
      ec[k] = |(er[k] | ef[k]);
      eo[k] = nw;
      for (int j = 0; j < len - 1; j++) sq[k][j] = sq[k][j+1];
      sq[k][len-1] = d;
   endtask

   // ---------------- compare process ----------------
   always @(posedge clk) begin
      for (int k = 0; k < 3; k++) begin
         if (reset) model_reset(k);
         else       model_step(k, din[k]);
      end
      #1;
      if (!reset) begin
         for (int k = 0; k < 3; k++) begin
            check($sformatf("model_dout%0d", k), 32'(dout[k]), 32'(eo[k]));
            check($sformatf("model_rise%0d", k), 32'(rise[k]), 32'(er[k]));
            check($sformatf("model_fall%0d", k), 32'(fall[k]), 32'(ef[k]));
            check($sformatf("model_changed%0d", k), 32'(chg[k]), 32'(ec[k]));
         end
      end
   end

   // ---------------- pulse monitor ----------------
   logic mon_en = 1'b0;
   int   mon_bad0  = 0;
   int   mon_rise2 = 0;
   always @(posedge clk) begin
      #1;
      if (mon_en) begin
         if (dout[0] != 8'h00 || rise[0] != 8'h00 || fall[0] != 8'h00 || chg[0]) mon_bad0++;
         if (rise[2][3]) mon_rise2++;
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      int e0, e2, nr, nc, nf, np, n;
      logic [7:0] got_r, got_f;
      int r;

      reset  = 1'b1;
      din[0] = 8'h00;
      din[1] = 8'hA5;
      din[2] = 8'h00;
      repeat (3) @(negedge clk);
      check("reset_dout0", 32'(dout[0]), 32'h00);
      check("reset_dout1", 32'(dout[1]), 32'hA5);
      check("reset_strobes", 32'({rise[0], fall[0], rise[1], fall[1]}), 32'h0);
      reset = 1'b0;

      // release with d_in at the reset value: nothing moves
      n = 0;
      for (int e = 0; e < 10; e++) begin
         @(posedge clk); #1;
         if (chg[0] || chg[1] || chg[2] || dout[1] != 8'hA5) n++;
      end
      check("release_quiet", 32'(n), 32'd0);

      // held step: latency 7 (defaults) and 5 (SYNC=3, STABLE=1)
      @(negedge clk);
      din[0] = 8'h01;
      din[2] = 8'h01;
      e0 = 0; e2 = 0; nr = 0; nc = 0;
      for (int e = 1; e <= 20; e++) begin
         @(posedge clk); #1;
         if (e0 == 0 && dout[0][0]) e0 = e;
         if (e2 == 0 && dout[2][0]) e2 = e;
         if (rise[0] == 8'h01) nr++;
         if (chg[0]) nc++;
      end
      check("step_latency_default", 32'(e0), 32'd7);
      check("step_latency_s1", 32'(e2), 32'd5);
      check("step_rise_cycles", 32'(nr), 32'd1);
      check("step_changed_cycles", 32'(nc), 32'd1);

      // short pulses on bit 3
      @(negedge clk);
      din[0] = 8'h00;
      din[2] = 8'h00;
      repeat (20) @(negedge clk);
      mon_en = 1'b1;
      for (int w = 1; w <= 3; w++) begin
         din[0] = 8'h08;
         din[2] = 8'h08;
         repeat (w) @(negedge clk);
         din[0] = 8'h00;
         din[2] = 8'h00;
         repeat (10) @(negedge clk);
         if (w == 1) check("s1_reject_1cycle", 32'(mon_rise2), 32'd0);
      end
      mon_en = 1'b0;
      check("pulses_rejected_default", 32'(mon_bad0), 32'd0);
      check("s1_pass_2_and_3", 32'(mon_rise2), 32'd2);

      // all bits 0x00 -> 0xFF -> 0x00
      nr = 0; nf = 0; nc = 0; np = 0;
      for (int e = 0; e < 45; e++) begin
         @(negedge clk);
         if (e == 0)  din[0] = 8'hFF;
         if (e == 20) din[0] = 8'h00;
         @(posedge clk); #1;
         if (rise[0] == 8'hFF) nr++;
         if (fall[0] == 8'hFF) nf++;
         if (chg[0]) nc++;
         if ((rise[0] != 8'h00 && rise[0] != 8'hFF) || (fall[0] != 8'h00 && fall[0] != 8'hFF)) np++;
      end
      check("bus_rise_ff", 32'(nr), 32'd1);
      check("bus_fall_ff", 32'(nf), 32'd1);
      check("bus_changed_cycles", 32'(nc), 32'd2);
      check("bus_partial_strobes", 32'(np), 32'd0);

      // non-zero reset value: 0xA5 -> 0x5A
      @(negedge clk);
      din[1] = 8'h5A;
      n = 0; got_r = 8'h00; got_f = 8'h00;
      for (int e = 0; e < 20; e++) begin
         @(posedge clk); #1;
         if (chg[1]) begin
            n++;
            got_r = rise[1];
            got_f = fall[1];
         end
      end
      check("rv_changed_cycles", 32'(n), 32'd1);
      check("rv_rise", 32'(got_r), 32'h5A);
      check("rv_fall", 32'(got_f), 32'hA5);

      // randomised traffic, checked by the model
      for (int c = 0; c < 600; c++) begin
         @(negedge clk);
         for (int k = 0; k < 3; k++) begin
            r = int'($urandom_range(0, 7));
            if (r == 0)      din[k] = 8'($urandom);
            else if (r == 1) din[k] = din[k] ^ (8'd1 << $urandom_range(0, 7));
         end
      end

      // asynchronous reset mid-count
      @(negedge clk);
      din[0] = 8'hF0;
      repeat (20) @(negedge clk);
      check("pre_reset_settled", 32'(dout[0]), 32'hF0);
      din[0] = 8'hF1;
      repeat (5) @(negedge clk);
      check("mid_count_hold", 32'(dout[0]), 32'hF0);
      #2 reset = 1'b1;
      #1;
      check("async_reset_dout0", 32'(dout[0]), 32'h00);
      check("async_reset_dout1", 32'(dout[1]), 32'hA5);
      check("async_reset_strobes", 32'({rise[0], fall[0], 7'd0, chg[0]}), 32'h0);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      e0 = 0;
      for (int e = 1; e <= 20; e++) begin
         @(posedge clk); #1;
         if (e0 == 0 && dout[0] == 8'hF1) e0 = e;
      end
      check("post_reset_latency", 32'(e0), 32'd7);

      repeat (5) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
